// File: rtl/ps2_kbd_ctrl.sv
// PS/2 set-2 keyboard controller: pops bytes from the receiver FIFO, folds E0/F0
// prefixes into key events, tracks shift/held-key state and hands events out on valid/ready.
module ps2_kbd_ctrl (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  input  logic       kb_overflow,
  output logic       kb_nextdata_n,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic [7:0] evt_ascii,
  output logic       shift,
  output logic [7:0] cur_key,
  output logic       key_held,
  output logic [7:0] press_count,
  output logic       ovf_seen
);

  typedef enum logic [1:0] {IDLE, POP, DECODE, EMIT} state_t;

  localparam logic [7:0] LETTER_CODE [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGIT_CODE [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  state_t     state_reg, state_next;
  logic [7:0] byte_reg, byte_next;
  logic       ext_pend_reg, ext_pend_next;
  logic       brk_pend_reg, brk_pend_next;
  logic       shift_l_reg, shift_l_next;
  logic       shift_r_reg, shift_r_next;
  logic [7:0] cur_key_reg, cur_key_next;
  logic       cur_ext_reg, cur_ext_next;
  logic       key_held_reg, key_held_next;
  logic [7:0] press_count_reg, press_count_next;
  logic       ovf_seen_reg, ovf_seen_next;
  logic       nextdata_n_reg, nextdata_n_next;
  logic       evt_valid_reg, evt_valid_next;
  logic [7:0] evt_code_reg, evt_code_next;
  logic       evt_ext_reg, evt_ext_next;
  logic       evt_break_reg, evt_break_next;
  logic [7:0] evt_ascii_reg, evt_ascii_next;

  logic [25:0] letter_hit;
  logic [9:0]  digit_hit;
  logic [7:0]  ascii_lookup;
  logic        shift_any;
  logic        same_key;
  logic        emit;

  genvar gi;
  generate
    for (gi = 0; gi < 26; gi++) begin : g_letter
      assign letter_hit[gi] = (byte_reg == LETTER_CODE[gi]);
    end
    for (gi = 0; gi < 10; gi++) begin : g_digit
      assign digit_hit[gi] = (byte_reg == DIGIT_CODE[gi]);
    end
  endgenerate

  assign shift_any = shift_l_reg | shift_r_reg;
  assign same_key  = (byte_reg == cur_key_reg) && (ext_pend_reg == cur_ext_reg);

  // Case follows shift as held before this byte, so a break carries its make's ASCII.
  always_comb begin
    ascii_lookup = 8'h00;
    if (!ext_pend_reg) begin
      if (byte_reg == 8'h29) ascii_lookup = 8'h20;
      for (int i = 0; i < 26; i++)
        if (letter_hit[i]) ascii_lookup = (shift_any ? 8'h41 : 8'h61) + 8'(i);
      for (int i = 0; i < 10; i++)
        if (digit_hit[i]) ascii_lookup = 8'h30 + 8'(i);
    end
  end

  always_comb begin
    state_next       = state_reg;
    byte_next        = byte_reg;
    ext_pend_next    = ext_pend_reg;
    brk_pend_next    = brk_pend_reg;
    shift_l_next     = shift_l_reg;
    shift_r_next     = shift_r_reg;
    cur_key_next     = cur_key_reg;
    cur_ext_next     = cur_ext_reg;
    key_held_next    = key_held_reg;
    press_count_next = press_count_reg;
    ovf_seen_next    = ovf_seen_reg | kb_overflow;
    nextdata_n_next  = 1'b1;
    evt_valid_next   = evt_valid_reg;
    evt_code_next    = evt_code_reg;
    evt_ext_next     = evt_ext_reg;
    evt_break_next   = evt_break_reg;
    evt_ascii_next   = evt_ascii_reg;
    emit             = 1'b0;
    case (state_reg)
      IDLE: begin
        if (kb_ready) begin
          byte_next       = kb_data;
          nextdata_n_next = 1'b0;
          state_next      = POP;
        end
      end
      POP: state_next = DECODE;
      DECODE: begin
        state_next = IDLE;
        if (byte_reg == 8'hE0) begin
          ext_pend_next = 1'b1;
        end else if (byte_reg == 8'hF0) begin
          brk_pend_next = 1'b1;
        end else begin
          ext_pend_next = 1'b0;
          brk_pend_next = 1'b0;
          // Shift keys only report a change of their own bit.
          if (byte_reg == 8'h12 && !ext_pend_reg) begin
            shift_l_next = !brk_pend_reg;
            emit         = (shift_l_reg == brk_pend_reg);
          end else if (byte_reg == 8'h59 && !ext_pend_reg) begin
            shift_r_next = !brk_pend_reg;
            emit         = (shift_r_reg == brk_pend_reg);
          end else if (!brk_pend_reg) begin
            if (!(key_held_reg && same_key)) begin
              cur_key_next  = byte_reg;
              cur_ext_next  = ext_pend_reg;
              key_held_next = 1'b1;
              emit          = 1'b1;
            end
          end else begin
            if (same_key) key_held_next = 1'b0;
            press_count_next = press_count_reg + 8'd1;
            emit             = 1'b1;
          end
          if (emit) begin
            evt_code_next  = byte_reg;
            evt_ext_next   = ext_pend_reg;
            evt_break_next = brk_pend_reg;
            evt_ascii_next = ascii_lookup;
            evt_valid_next = 1'b1;
            state_next     = EMIT;
          end
        end
      end
      EMIT: begin
        if (evt_ready) begin
          evt_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_reg       <= IDLE;
      byte_reg        <= 8'h00;
      ext_pend_reg    <= 1'b0;
      brk_pend_reg    <= 1'b0;
      shift_l_reg     <= 1'b0;
      shift_r_reg     <= 1'b0;
      cur_key_reg     <= 8'h00;
      cur_ext_reg     <= 1'b0;
      key_held_reg    <= 1'b0;
      press_count_reg <= 8'h00;
      ovf_seen_reg    <= 1'b0;
      nextdata_n_reg  <= 1'b1;
      evt_valid_reg   <= 1'b0;
      evt_code_reg    <= 8'h00;
      evt_ext_reg     <= 1'b0;
      evt_break_reg   <= 1'b0;
      evt_ascii_reg   <= 8'h00;
    end else begin
      state_reg       <= state_next;
      byte_reg        <= byte_next;
      ext_pend_reg    <= ext_pend_next;
      brk_pend_reg    <= brk_pend_next;
      shift_l_reg     <= shift_l_next;
      shift_r_reg     <= shift_r_next;
      cur_key_reg     <= cur_key_next;
      cur_ext_reg     <= cur_ext_next;
      key_held_reg    <= key_held_next;
      press_count_reg <= press_count_next;
      ovf_seen_reg    <= ovf_seen_next;
      nextdata_n_reg  <= nextdata_n_next;
      evt_valid_reg   <= evt_valid_next;
      evt_code_reg    <= evt_code_next;
      evt_ext_reg     <= evt_ext_next;
      evt_break_reg   <= evt_break_next;
      evt_ascii_reg   <= evt_ascii_next;
    end
  end

  assign kb_nextdata_n = nextdata_n_reg;
  assign evt_valid     = evt_valid_reg;
  assign evt_code      = evt_code_reg;
  assign evt_ext       = evt_ext_reg;
  assign evt_break     = evt_break_reg;
  assign evt_ascii     = evt_ascii_reg;
  assign shift         = shift_any;
  assign cur_key       = cur_key_reg;
  assign key_held      = key_held_reg;
  assign press_count   = press_count_reg;
  assign ovf_seen      = ovf_seen_reg;

endmodule

// File: doc/ps2_kbd_ctrl.md
# ps2_kbd_ctrl

Controller that sits between the `ps2_keyboard` receiver FIFO and downstream consumers such as the display or text logic. It drains scan-code bytes by sequencing the receiver's `nextdata_n` pop strobe. It parses PS/2 set-2 prefixes (`E0` extended, `F0` break), tracks held-key and shift state, suppresses typematic repeats, and presents one decoded key event at a time on a valid/ready handshake.

## Interface
- No parameters.
- `clk` in 1: system clock, same clock as the receiver.
- `clrn` in 1: reset, synchronous, active-low.
- `kb_data` in 8: receiver FIFO head byte; valid while `kb_ready`=1.
- `kb_ready` in 1: receiver FIFO non-empty.
- `kb_overflow` in 1: receiver overflow flag.
- `kb_nextdata_n` out 1: pop strobe, active-low, registered.
- `evt_valid` out 1: event available.
- `evt_ready` in 1: consumer accepts event.
- `evt_code` out 8: scan code, prefixes stripped.
- `evt_ext` out 1: event was `E0`-prefixed.
- `evt_break` out 1: 1 = release, 0 = press.
- `evt_ascii` out 8: ASCII for the key, `00` if unmapped.
- `shift` out 1: left or right shift currently held.
- `cur_key` out 8: last non-shift key pressed.
- `key_held` out 1: `cur_key` still down.
- `press_count` out 8: completed non-shift keystrokes, counted at release, wraps at 255→0.
- `ovf_seen` out 1: sticky copy of `kb_overflow`.

## Operation
- **Reset values** (`clrn`=0 at a clk edge): state IDLE, `kb_nextdata_n`=1, `evt_valid`=0, all other outputs 0, `ext_pend`=0, `brk_pend`=0, left/right shift bits 0.
  - Reset mid-transfer or mid-EMIT drops the pending event and any prefixes.
- **IDLE:** if `kb_ready`=1, latch `kb_data` into `byte_r` and go to POP. Otherwise stay.
- **POP:** `kb_nextdata_n`=0 for exactly this one cycle, then go to DECODE. Exactly one pop per accepted byte.
- **DECODE:** `kb_nextdata_n`=1.
  - `byte_r`=`E0`: set `ext_pend`, go to IDLE.
  - `byte_r`=`F0`: set `brk_pend`, go to IDLE.
  - Otherwise the byte is key `k`, with extended bit `x`=`ext_pend` and break bit `b`=`brk_pend`.
- **Shift keys** (`k`=`12` or `59`, `x`=0):
  - Update the corresponding shift bit (`b`=0 sets it, `b`=1 clears it).
  - Emit an event only if that bit changes. A repeated make while already held is suppressed.
  - Shift keys never touch `cur_key`, `key_held` or `press_count`.
- **Other make** (`b`=0):
  - If `key_held`=1 and `k`=`cur_key` and `x` equals the stored ext bit, it is a typematic repeat: suppress it, no event.
  - Otherwise set `cur_key`=`k`, store `x`, set `key_held`=1, and emit.
- **Other break** (`b`=1):
  - If `k`=`cur_key` and `x` matches, clear `key_held`.
  - Increment `press_count`.
  - Emit.
- **After DECODE:** clear `ext_pend`/`brk_pend`, then go to EMIT if emitting, else IDLE.
- **EMIT:**
  - `evt_*` fields are registered at DECODE exit and held stable with `evt_valid`=1 until `evt_ready`=1.
  - On the accept cycle go to IDLE with `evt_valid`=0 next cycle.
  - No pops occur during EMIT. A stalled consumer backs up the receiver FIFO, whose overflow is reported via `ovf_seen`.
- **ASCII map** (`x`=0 only, else `00`), standard set-2 codes:
  - Letters: a `1C`, b `32`, c `21`, d `23`, e `24`, f `2B`, g `34`, h `33`, i `43`, j `3B`, k `42`, l `4B`, m `3A`, n `31`, o `44`, p `4D`, q `15`, r `2D`, s `1B`, t `2C`, u `3C`, v `2A`, w `1D`, x `22`, y `35`, z `1A`.
  - Letters are lowercase, or uppercase when `shift`=1 at decode time.
  - Digits 0–9: `45`, `16`, `1E`, `26`, `25`, `2E`, `36`, `3D`, `3E`, `46`, unaffected by shift.
  - Space: `29`→`20`.
  - Break events carry the same ASCII as the make.
- **Prefix sequences:** `E0 F0` in either order sets both pend bits. Consecutive `F0 F0` is equivalent to a single `F0`.
- **`ovf_seen`:** set when `kb_overflow`=1, cleared only by reset.

## Timing
- Minimum 3 cycles per byte (IDLE→POP→DECODE), so `kb_data` is sampled only in IDLE.
- The receiver's `ready` is updated on the edge ending POP, so the IDLE following DECODE sees the true post-pop status.
- Event latency: `evt_valid` rises 3 cycles after the final byte of a sequence is seen with `kb_ready`=1 in IDLE.
- With `evt_ready` tied to 1: at most one event per 4 cycles, and `evt_valid` is a 1-cycle pulse.
- `evt_ready` asserted with `evt_valid`=0 has no effect.
- `shift`, `cur_key`, `key_held` and `press_count` update on the DECODE→next edge, i.e. the same edge on which `evt_valid` rises.

## Test plan
- Bytes `1C`, `F0 1C` with `evt_ready`=1 → two events: code `1C` break 0 ascii `61`, then break 1 ascii `61`. `press_count`=1, `key_held`=0, exactly 3 `kb_nextdata_n` low pulses.
- `12`, `1C`, `F0 1C`, `F0 12` → 4 events. Ascii `41` on the `1C` make. `shift` reads 1 then 0. `cur_key`=`1C`, `press_count`=1.
- Typematic: `24` ×5 then `F0 24` → only 2 events (make, break). Repeated `12` ×3 → 1 event.
- `E0 75`, `E0 F0 75` → events with ext=1, ascii `00`, break 0 then 1.
- `evt_ready`=0 for 20 cycles after the first event with `16`, `1E` queued → `evt_*` stable, no pops. On release the events arrive in order with ascii `31`, `32`.
- Drive `clrn`=0 during EMIT → next cycle `evt_valid`=0, `kb_nextdata_n`=1, all counters and state 0. A following `F0`-free byte decodes as a make.
